// File: rtl/reg_status_file_if.sv
// reg_status_file_if: rename, commit and dispatch-read bus for the register status file
//   params : XLEN data width, TAG_W ROB tag width
//   rdy/clear               global enable and ROB flush
//   ID_*                    rename request (dest register, allocated tag)
//   commit_*                in-order ROB commit (reg, tag, data)
//   dispatch_reg{1,2}_*     two combinational operand read ports
//   busy_count              registered number of busy registers
//   modports: master drives requests, slave is the register file
`timescale 1ns/1ps
interface reg_status_file_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             rdy;
    logic             clear;
    logic             ID_valid;
    logic [4:0]       ID_dest_reg;
    logic [TAG_W-1:0] ID_tag;
    logic             commit_valid;
    logic [4:0]       commit_reg;
    logic [TAG_W-1:0] commit_tag;
    logic [XLEN-1:0]  commit_data;
    logic [4:0]       dispatch_reg1_addr;
    logic [4:0]       dispatch_reg2_addr;
    logic             dispatch_reg1_valid;
    logic             dispatch_reg2_valid;
    logic [XLEN-1:0]  dispatch_reg1_data;
    logic [XLEN-1:0]  dispatch_reg2_data;
    logic [TAG_W-1:0] dispatch_reg1_tag;
    logic [TAG_W-1:0] dispatch_reg2_tag;
    logic [5:0]       busy_count;

    modport master (
        output rdy, clear, ID_valid, ID_dest_reg, ID_tag,
               commit_valid, commit_reg, commit_tag, commit_data,
               dispatch_reg1_addr, dispatch_reg2_addr,
        input  dispatch_reg1_valid, dispatch_reg2_valid, dispatch_reg1_data,
               dispatch_reg2_data, dispatch_reg1_tag, dispatch_reg2_tag, busy_count
    );

    modport slave (
        input  rdy, clear, ID_valid, ID_dest_reg, ID_tag,
               commit_valid, commit_reg, commit_tag, commit_data,
               dispatch_reg1_addr, dispatch_reg2_addr,
        output dispatch_reg1_valid, dispatch_reg2_valid, dispatch_reg1_data,
               dispatch_reg2_data, dispatch_reg1_tag, dispatch_reg2_tag, busy_count
    );
endinterface

// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with per-register busy bit and producer ROB tag
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   bus      reg_status_file_if.slave: rename (ID_*), commit (commit_*), flush (clear),
//            enable (rdy), two combinational dispatch read ports, busy_count
`timescale 1ns/1ps
module reg_status_file #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int TAG_W   = 4
) (
    input logic               clk,
    input logic               rst,
    reg_status_file_if.slave  bus
);
    logic [XLEN-1:0]    data_q [REG_NUM];
    logic [XLEN-1:0]    data_d [REG_NUM];
    logic [TAG_W-1:0]   tag_q  [REG_NUM];
    logic [TAG_W-1:0]   tag_d  [REG_NUM];
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [5:0]         busy_count_q, busy_count_d;

    // Statement order encodes priority: rename overrides a same-cycle commit
    // clearing busy, and flush overrides both, while commit data always lands.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (bus.rdy) begin
            if (bus.commit_valid && bus.commit_reg != '0) begin
                data_d[bus.commit_reg] = bus.commit_data;
                if (tag_q[bus.commit_reg] == bus.commit_tag)
                    busy_d[bus.commit_reg] = 1'b0;
            end
            if (bus.clear) begin
                busy_d = '0;
                for (int i = 0; i < REG_NUM; i++)
                    tag_d[i] = '0;
            end else if (bus.ID_valid && bus.ID_dest_reg != '0) begin
                busy_d[bus.ID_dest_reg] = 1'b1;
                tag_d[bus.ID_dest_reg]  = bus.ID_tag;
            end
        end
        busy_count_d = '0;
        for (int i = 0; i < REG_NUM; i++)
            busy_count_d = busy_count_d + 6'(busy_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            data_q       <= data_d;
            tag_q        <= tag_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Entry 0 is never written or marked busy, so it naturally reads valid zero.
    for (genvar g = 0; g < 2; g++) begin : g_rd
        logic [4:0]       a;
        logic             v;
        logic [XLEN-1:0]  d;
        logic [TAG_W-1:0] t;
        assign a = (g == 0) ? bus.dispatch_reg1_addr : bus.dispatch_reg2_addr;
        always_comb begin
            v = 1'b1;
            d = data_q[a];
            t = '0;
            if (busy_q[a]) begin
                if (bus.commit_valid && bus.commit_reg == a && bus.commit_tag == tag_q[a])
                    d = bus.commit_data;
                else begin
                    v = 1'b0;
                    d = '0;
                    t = tag_q[a];
                end
            end
        end
    end

    assign bus.dispatch_reg1_valid = g_rd[0].v;
    assign bus.dispatch_reg1_data  = g_rd[0].d;
    assign bus.dispatch_reg1_tag   = g_rd[0].t;
    assign bus.dispatch_reg2_valid = g_rd[1].v;
    assign bus.dispatch_reg2_data  = g_rd[1].d;
    assign bus.dispatch_reg2_tag   = g_rd[1].t;
    assign bus.busy_count          = busy_count_q;
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed self-checking bench for reg_status_file
`timescale 1ns/1ps
module tb_reg_status_file;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    reg_status_file_if #(.XLEN(32), .TAG_W(4)) bus ();
    reg_status_file dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd1(input string name, input logic v, input logic [31:0] d, input logic [3:0] t);
        #1;
        chk({name, ".v"}, 64'(bus.dispatch_reg1_valid), 64'(v));
        chk({name, ".d"}, 64'(bus.dispatch_reg1_data), 64'(d));
        chk({name, ".t"}, 64'(bus.dispatch_reg1_tag), 64'(t));
    endtask

    task automatic rd2(input string name, input logic v, input logic [31:0] d, input logic [3:0] t);
        #1;
        chk({name, ".v"}, 64'(bus.dispatch_reg2_valid), 64'(v));
        chk({name, ".d"}, 64'(bus.dispatch_reg2_data), 64'(d));
        chk({name, ".t"}, 64'(bus.dispatch_reg2_tag), 64'(t));
    endtask

    task automatic cnt(input string name, input int n);
        chk(name, 64'(bus.busy_count), 64'(n));
    endtask

    task automatic ren(input logic [4:0] r, input logic [3:0] t);
        bus.ID_valid = 1'b1; bus.ID_dest_reg = r; bus.ID_tag = t;
    endtask

    task automatic com(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
        bus.commit_valid = 1'b1; bus.commit_reg = r; bus.commit_tag = t; bus.commit_data = d;
    endtask

    task automatic idle();
        bus.ID_valid = 1'b0; bus.commit_valid = 1'b0; bus.clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.ID_dest_reg = '0; bus.ID_tag = '0;
        bus.commit_reg = '0; bus.commit_tag = '0; bus.commit_data = '0;
        bus.dispatch_reg1_addr = '0; bus.dispatch_reg2_addr = '0;
        idle();
        tick(); tick();
        rst = 1'b0;

        bus.dispatch_reg1_addr = 5'd5; bus.dispatch_reg2_addr = 5'd0;
        rd1("rst_x5", 1'b1, 32'h0, 4'h0);
        rd2("rst_x0", 1'b1, 32'h0, 4'h0);
        cnt("rst_cnt", 0);

        ren(5, 3); tick(); idle();
        rd1("ren_x5", 1'b0, 32'h0, 4'h3);
        cnt("ren_cnt", 1);
        com(5, 3, 32'hDEADBEEF);
        rd1("bypass_x5", 1'b1, 32'hDEADBEEF, 4'h0);
        tick(); idle();
        rd1("array_x5", 1'b1, 32'hDEADBEEF, 4'h0);
        cnt("commit_cnt", 0);

        bus.dispatch_reg1_addr = 5'd7;
        ren(7, 2); tick(); ren(7, 6); tick(); idle();
        com(7, 2, 32'h11);
        rd1("stale_nobypass_x7", 1'b0, 32'h0, 4'h6);
        tick(); idle();
        rd1("stale_x7", 1'b0, 32'h0, 4'h6);
        cnt("stale_cnt", 1);
        com(7, 6, 32'h22); tick(); idle();
        rd1("young_x7", 1'b1, 32'h22, 4'h0);
        cnt("young_cnt", 0);

        bus.dispatch_reg1_addr = 5'd9;
        ren(9, 4); tick();
        com(9, 4, 32'h99); ren(9, 9); tick(); idle();
        rd1("race_x9", 1'b0, 32'h0, 4'h9);
        cnt("race_cnt", 1);
        bus.clear = 1'b1; tick(); idle();
        rd1("race_data_x9", 1'b1, 32'h99, 4'h0);
        cnt("clear9_cnt", 0);

        ren(1, 1); tick(); ren(2, 2); tick(); ren(3, 3); tick(); idle();
        cnt("three_cnt", 3);
        bus.clear = 1'b1; ren(4, 5); com(1, 1, 32'h55); tick(); idle();
        bus.dispatch_reg1_addr = 5'd1; bus.dispatch_reg2_addr = 5'd4;
        rd1("flush_x1", 1'b1, 32'h55, 4'h0);
        rd2("flush_x4", 1'b1, 32'h0, 4'h0);
        bus.dispatch_reg2_addr = 5'd2;
        rd2("flush_x2", 1'b1, 32'h0, 4'h0);
        cnt("flush_cnt", 0);

        ren(0, 7); com(0, 7, 32'hFF); tick(); idle();
        bus.dispatch_reg1_addr = 5'd0;
        rd1("x0_zero", 1'b1, 32'h0, 4'h0);
        cnt("x0_cnt", 0);

        bus.rdy = 1'b0; ren(10, 8); com(5, 0, 32'h1234); bus.clear = 1'b0; tick();
        bus.rdy = 1'b1; idle();
        bus.dispatch_reg1_addr = 5'd10; bus.dispatch_reg2_addr = 5'd5;
        rd1("hold_x10", 1'b1, 32'h0, 4'h0);
        rd2("hold_x5", 1'b1, 32'hDEADBEEF, 4'h0);
        cnt("hold_cnt", 0);

        ren(11, 1); tick(); idle();
        cnt("pre_rst_cnt", 1);
        rst = 1'b1; com(5, 0, 32'h777); tick(); rst = 1'b0; idle();
        bus.dispatch_reg1_addr = 5'd11;
        rd1("rst_x11", 1'b1, 32'h0, 4'h0);
        rd2("rst2_x5", 1'b1, 32'h0, 4'h0);
        cnt("rst2_cnt", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/reg_status_file.md
# reg_status_file

Architectural register file with per-register rename status, sitting directly downstream of the reorder buffer's commit/CDB output and upstream of dispatch. Each entry holds a committed value, a busy bit and the ROB tag of its youngest in-flight producer. ID renames destinations into it. Dispatch reads operands from it, getting either committed data or the tag to look up in the ROB. The ROB's in-order commit writes it back and retires the busy status.

## Interface
- `XLEN`, 32, data width
- `REG_NUM`, 32, architectural registers; register 0 is hardwired zero
- `TAG_W`, 4, ROB tag width (ROB depth 2^TAG_W)
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `rdy`  in  1  global enable; low freezes all state
- `clear`  in  1  flush from ROB; drops all rename status
- `ID_valid`  in  1  rename request this cycle
- `ID_dest_reg`  in  5  destination register to rename
- `ID_tag`  in  TAG_W  ROB tag allocated to that instruction
- `commit_valid`  in  1  ROB commit writes a register (ROB `CDB_valid`)
- `commit_reg`  in  5  committed destination
- `commit_tag`  in  TAG_W  ROB tag of committed instruction
- `commit_data`  in  XLEN  committed value
- `dispatch_reg1_addr`, `dispatch_reg2_addr`  in  5 each  source operand indices
- `dispatch_reg1_valid`, `dispatch_reg2_valid`  out  1 each  1 means data is final; 0 means wait on the tag
- `dispatch_reg1_data`, `dispatch_reg2_data`  out  XLEN each  operand value, 0 when not valid
- `dispatch_reg1_tag`, `dispatch_reg2_tag`  out  TAG_W each  producer tag when not valid, 0 otherwise
- `busy_count`  out  6  number of registers currently busy

## Operation
- State per entry r: `data[r]`, `busy[r]`, `tag[r]`. Entry 0 is never written and never busy. It always reads 0 with valid=1.
- Read port n, address a, combinational:
  - If a=0 or !busy[a], the output is valid=1, data=data[a], tag=0.
  - Else if commit_valid && commit_reg==a && commit_tag==tag[a], this is the commit bypass. The output is valid=1, data=commit_data, tag=0.
  - Otherwise the output is valid=0, data=0, tag=tag[a].
  - Reads see pre-rename state. A same-cycle ID rename never affects a same-cycle read, because an instruction's sources precede its own destination.
- Commit, on an edge with rdy, !rst and commit_valid, when commit_reg≠0:
  - data[commit_reg] ← commit_data.
  - busy[commit_reg] is cleared only if tag[commit_reg]==commit_tag and no rename of the same register occurs this cycle.
  - A tag mismatch means a younger producer owns the register. In that case only data is written.
- Rename, on an edge with rdy, !rst, !clear and ID_valid, when ID_dest_reg≠0: busy ← 1, tag ← ID_tag.
- Rename and commit to the same register in one cycle: the rename wins the busy and tag fields, and the commit still writes data.
- Flush, on an edge with rdy and clear:
  - All busy bits and tags go to 0, and any same-cycle rename is discarded.
  - A same-cycle commit_valid still writes data, because it is architecturally retired.
- busy_count is a registered popcount of the next-state busy vector. Range is 0..31, no wrap.

## Timing
- Reads have zero latency, combinational from addr and state, and from the commit_* inputs for the bypass.
- Rename becomes visible to reads the cycle after ID_valid.
- Commit data becomes visible to reads in the same cycle via the bypass, and from the array on the next cycle.
- Priority for busy/tag: rst > !rdy (hold) > clear > rename > commit-clear.
- Reset: all data 0, busy 0, tag 0, busy_count 0. The read outputs then show valid=1, data=0, tag=0 for every address.
- Reset asserted mid-operation discards all renames and data on that edge. Commits arriving on the reset edge are lost.
- While rdy=0, no state changes and inputs are ignored. Reads stay live.
- Tag wrap: tags are compared for equality only, so the ROB reusing a tag after wrap-around is safe provided an older tag can't commit after the reuse.

## Test plan
- Reset, then read x5 and x0 → both valid=1, data=0; busy_count=0.
- Rename x5 to tag 3; next cycle read x5 → valid=0, tag=3. Commit x5/tag 3/0xDEADBEEF in the same cycle as a read → valid=1, data=0xDEADBEEF (bypass). Next cycle, array read → same value; busy_count=0.
- Rename x7 to tag 2, then x7 to tag 6. Commit x7/tag 2/0x11 → x7 stays busy with tag 6 and data=0x11. Commit tag 6/0x22 → x7 valid with 0x22.
- Commit x9/tag 4 and rename x9 to tag 9 on the same edge → x9 busy with tag 9, data updated.
- Rename x1, x2, x3 (busy_count=3), then clear with a simultaneous rename of x4 and commit of x1/0x55 → all valid, x1=0x55, x4 not busy, busy_count=0.
- Rename x0 and commit x0/0xFF → x0 still reads valid 0. Hold rdy=0 during a rename → no state change.
